issue_execute_wakeup: RTL and testbench

Consumer end of the unified issue queue's three issue lanes. Executes ALU ops on lanes 0/1 and address-generates and sequences loads/stores to data memory on lane 2. Returns per-FU ready flags, three result broadcasts (tag, data, ROB number) and a 64-entry physical-register ready scoreboard that feed the issue queue's wakeup inputs.

---
 rtl/issue_execute_wakeup_pkg.sv | 15 +
 rtl/issue_execute_wakeup_if.sv | 37 +++
 rtl/issue_execute_wakeup_simple_alu.sv | 21 ++
 rtl/issue_execute_wakeup.sv | 115 +++++++++++
 tb/tb_issue_execute_wakeup.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_execute_wakeup_pkg.sv
// issue_execute_wakeup_pkg: optype codes, sizing constants and lane-2 FSM states shared by the execute slice.
package issue_execute_wakeup_pkg;
   localparam int PREGS = 64;
   localparam int XLEN = 32;
   localparam int TAGW = $clog2(PREGS);
   localparam logic [3:0] OP_ADD = 4'd1, OP_ADDI = 4'd2, OP_LUI = 4'd3, OP_ORI = 4'd4, OP_XOR = 4'd5,
                          OP_SRAI = 4'd6, OP_LB = 4'd7, OP_LW = 4'd8, OP_SB = 4'd9, OP_SW = 4'd10;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;
   function automatic logic is_alu(input logic [3:0] op);
      return op >= OP_ADD && op <= OP_SRAI;
   endfunction
   function automatic logic is_mem(input logic [3:0] op);
      return op >= OP_LB && op <= OP_SW;
   endfunction
endpackage

// File: rtl/issue_execute_wakeup_if.sv
// issue_execute_wakeup_if: three issue lanes, result broadcasts, wakeup scoreboard and data-memory port.
interface issue_execute_wakeup_if #(
   parameter int PREGS = issue_execute_wakeup_pkg::PREGS,
   parameter int XLEN = issue_execute_wakeup_pkg::XLEN
);
   localparam int TW = $clog2(PREGS);
   logic [2:0] issue_valid;
   logic [2:0][3:0] issue_optype;
   logic [2:0][31:0] issue_pc;
   logic [2:0][XLEN-1:0] issue_src1, issue_src2, issue_imm;
   logic [2:0][TW-1:0] issue_dest, issue_rob;
   logic [2:0] fu_ready, bcast_valid;
   logic [2:0][TW-1:0] bcast_preg, bcast_rob;
   logic [2:0][XLEN-1:0] bcast_data;
   logic store_done_valid;
   logic [TW-1:0] store_done_rob;
   logic alloc_valid;
   logic [TW-1:0] alloc_preg;
   logic [PREGS-1:0] preg_ready;
   logic mem_req_valid, mem_req_ready, mem_req_we;
   logic [XLEN-1:0] mem_req_addr, mem_req_wdata;
   logic [3:0] mem_req_be;
   logic mem_resp_valid;
   logic [XLEN-1:0] mem_resp_data;
   modport master (
      output issue_valid, issue_optype, issue_pc, issue_src1, issue_src2, issue_imm, issue_dest, issue_rob,
      output alloc_valid, alloc_preg, mem_req_ready, mem_resp_valid, mem_resp_data,
      input fu_ready, bcast_valid, bcast_preg, bcast_rob, bcast_data, store_done_valid, store_done_rob,
      input preg_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be
   );
   modport slave (
      input issue_valid, issue_optype, issue_pc, issue_src1, issue_src2, issue_imm, issue_dest, issue_rob,
      input alloc_valid, alloc_preg, mem_req_ready, mem_resp_valid, mem_resp_data,
      output fu_ready, bcast_valid, bcast_preg, bcast_rob, bcast_data, store_done_valid, store_done_rob,
      output preg_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be
   );
endinterface

// File: rtl/issue_execute_wakeup_simple_alu.sv
// simple_alu: combinational single-cycle ALU used by issue lanes 0 and 1.
module simple_alu import issue_execute_wakeup_pkg::*; #(
   parameter int XLEN = issue_execute_wakeup_pkg::XLEN
) (
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] result
);
   logic signed [XLEN-1:0] sra;
   // kept apart so the surrounding unsigned ternary cannot strip the sign
   assign sra = $signed(src1) >>> imm[4:0];
   always_comb
      result = op == OP_ADD  ? src1 + src2 :
               op == OP_ADDI ? src1 + imm :
               op == OP_XOR  ? src1 ^ src2 :
               op == OP_ORI  ? src1 | imm :
               op == OP_SRAI ? sra :
               op == OP_LUI  ? imm : '0;
endmodule

// File: rtl/issue_execute_wakeup.sv
// issue_execute_wakeup: ALU lanes 0/1, load/store lane 2 and the physical-register wakeup scoreboard.
// Optional WAKEUP_BYPASS_EN ORs same-cycle broadcast tags into preg_ready.
module issue_execute_wakeup import issue_execute_wakeup_pkg::*; #(
   parameter int PREGS = issue_execute_wakeup_pkg::PREGS,
   parameter int XLEN = issue_execute_wakeup_pkg::XLEN
) (
   input logic clk,
   input logic rst,
   issue_execute_wakeup_if.slave io
);
   localparam int TW = $clog2(PREGS);
   logic unused;
   logic [1:0] alu_acc, alu_vld;
   logic [1:0][XLEN-1:0] alu_res, alu_data;
   logic [1:0][TW-1:0] alu_preg, alu_rob;
   lsu_state_e state, state_nx;
   logic acc2, hs, fu_rdy2, req_vld, ld_vld, req_we, ld_lb, st_vld;
   logic [XLEN-1:0] ea, req_addr, req_wdata, ld_data;
   logic [3:0] req_be;
   logic [7:0] rbyte;
   logic [TW-1:0] l2_preg, l2_rob, st_rob;
   logic [2:0] b_vld;
   logic [2:0][TW-1:0] b_preg;
   logic [PREGS-1:0] sb, set_m, clr_m;
   assign unused = ^io.issue_pc;
   for (genvar i = 0; i < 2; i++) begin : g_alu
      simple_alu #(.XLEN(XLEN)) u_alu (.op(io.issue_optype[i]), .src1(io.issue_src1[i]), .src2(io.issue_src2[i]),
                                       .imm(io.issue_imm[i]), .result(alu_res[i]));
      assign alu_acc[i] = io.issue_valid[i] & is_alu(io.issue_optype[i]);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         alu_vld <= '0;
         alu_preg <= '0;
         alu_rob <= '0;
         alu_data <= '0;
      end else begin
         alu_vld <= alu_acc;
         alu_preg <= io.issue_dest[1:0];
         alu_rob <= io.issue_rob[1:0];
         alu_data <= alu_res;
      end
   assign acc2 = io.issue_valid[2] & fu_rdy2 & is_mem(io.issue_optype[2]);
   assign hs = req_vld & io.mem_req_ready;
   assign ea = io.issue_src1[2] + io.issue_imm[2];
   assign rbyte = io.mem_resp_data[8*req_addr[1:0] +: 8];
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_IDLE;
      else state <= state_nx;
   always_comb
      state_nx = state == S_IDLE ? (acc2 ? S_REQ : S_IDLE) :
                 state == S_REQ  ? (!hs ? S_REQ : req_we ? S_IDLE : S_WAIT) :
                 state == S_WAIT ? (io.mem_resp_valid ? S_DONE : S_WAIT) : S_IDLE;
   always_comb begin
      fu_rdy2 = state == S_IDLE;
      req_vld = state == S_REQ;
      ld_vld = state == S_DONE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         req_we <= 1'b0;
         req_addr <= '0;
         req_wdata <= '0;
         req_be <= '0;
         ld_lb <= 1'b0;
         l2_preg <= '0;
         l2_rob <= '0;
         ld_data <= '0;
         st_vld <= 1'b0;
         st_rob <= '0;
      end else begin
         if (acc2) begin
            req_we <= io.issue_optype[2] == OP_SB || io.issue_optype[2] == OP_SW;
            req_addr <= ea;
            req_wdata <= io.issue_optype[2] == OP_SB ? {(XLEN/8){io.issue_src2[2][7:0]}} : io.issue_src2[2];
            req_be <= io.issue_optype[2] inside {OP_LB, OP_SB} ? 4'b0001 << ea[1:0] : 4'hF;
            ld_lb <= io.issue_optype[2] == OP_LB;
            l2_preg <= io.issue_dest[2];
            l2_rob <= io.issue_rob[2];
         end
         if (state == S_WAIT && io.mem_resp_valid)
            ld_data <= ld_lb ? {{(XLEN-8){rbyte[7]}}, rbyte} : io.mem_resp_data;
         st_vld <= hs & req_we;
         if (hs) st_rob <= l2_rob;
      end
   assign b_vld = {ld_vld, alu_vld};
   assign b_preg = {l2_preg, alu_preg};
   assign io.fu_ready = {fu_rdy2, 2'b11};
   assign io.bcast_valid = b_vld;
   assign io.bcast_preg = b_preg;
   assign io.bcast_rob = {l2_rob, alu_rob};
   assign io.bcast_data = {ld_data, alu_data};
   assign io.store_done_valid = st_vld;
   assign io.store_done_rob = st_rob;
   assign io.mem_req_valid = req_vld;
   assign io.mem_req_we = req_we;
   assign io.mem_req_addr = req_addr;
   assign io.mem_req_wdata = req_wdata;
   assign io.mem_req_be = req_be;
   always_comb begin
      set_m = '0;
      for (int k = 0; k < 3; k++)
         set_m = set_m | (b_vld[k] ? PREGS'(1) << b_preg[k] : '0);
      clr_m = io.alloc_valid ? PREGS'(1) << io.alloc_preg : '0;
   end
   // clear beats set on the same register; register 0 is pinned ready
   always_ff @(posedge clk or posedge rst)
      if (rst) sb <= '1;
      else sb <= ((sb | set_m) & ~clr_m) | PREGS'(1);
`ifdef WAKEUP_BYPASS_EN
   assign io.preg_ready = sb | (set_m & ~clr_m);
`else
   assign io.preg_ready = sb;
`endif
endmodule

// File: tb/tb_issue_execute_wakeup.sv
// tb_issue_execute_wakeup: randomized scoreboard bench; expected broadcasts, store completions and
// wakeup bits come from a behavioural model of the lanes, the memory and the ready set.
`timescale 1ns/1ps
module tb_issue_execute_wakeup;
   import issue_execute_wakeup_pkg::*;
   typedef struct {int due; logic [5:0] preg; logic [5:0] rob; logic [31:0] data;} exp_t;
   typedef struct {int due; logic [5:0] rob;} st_t;
   logic clk = 1'b0, rst = 1'b1;
   int cyc = 0, vectors = 0, miscompares = 0;
   logic [1:0] a_v;
   logic [1:0][3:0] a_op;
   logic [1:0][31:0] a_s1, a_s2, a_imm;
   logic [1:0][5:0] a_d, a_r;
   logic l_v, al_v, m_rdy, m_rv;
   logic [3:0] l_op;
   logic [31:0] l_s1, l_s2, l_imm, m_rd;
   logic [5:0] l_d, l_r, al_p;
   logic [63:0] rdy, setm_q;
   exp_t qa[3][$];
   st_t sq[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   issue_execute_wakeup_if #(.PREGS(64), .XLEN(32)) io ();
   issue_execute_wakeup #(.PREGS(64), .XLEN(32)) dut (.clk(clk), .rst(rst), .io(io));
   assign io.issue_valid = {l_v, a_v};
   assign io.issue_optype = {l_op, a_op};
   assign io.issue_pc = {32'h300, 32'h200, 32'h100};
   assign io.issue_src1 = {l_s1, a_s1};
   assign io.issue_src2 = {l_s2, a_s2};
   assign io.issue_imm = {l_imm, a_imm};
   assign io.issue_dest = {l_d, a_d};
   assign io.issue_rob = {l_r, a_r};
   assign io.alloc_valid = al_v;
   assign io.alloc_preg = al_p;
   assign io.mem_req_ready = m_rdy;
   assign io.mem_resp_valid = m_rv;
   assign io.mem_resp_data = m_rd;
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b, imm);
      int unsigned sh;
      sh = imm[4:0];
      case (op)
         4'd1: return a + b;
         4'd2: return a + imm;
         4'd3: return imm;
         4'd4: return a | imm;
         4'd5: return a ^ b;
         4'd6: return a[31] ? ~(~a >> sh) : a >> sh;
         default: return 32'h0;
      endcase
   endfunction
   task automatic alu(input int k, input logic [3:0] op, input logic [31:0] s1, s2, imm,
                      input logic [5:0] d, r, input logic v);
      a_v[k] = v; a_op[k] = op; a_s1[k] = s1; a_s2[k] = s2; a_imm[k] = imm; a_d[k] = d; a_r[k] = r;
      if (v && op >= 4'd1 && op <= 4'd6) qa[k].push_back('{cyc + 1, d, r, ref_alu(op, s1, s2, imm)});
   endtask
   task automatic mem_op(input logic [3:0] op, input logic [31:0] s1, s2, imm, input logic [5:0] d, r,
                         input int rd_dly, rs_dly, input logic [31:0] rdata);
      logic [31:0] ea, wd, res;
      logic [7:0] b8;
      logic [3:0] be;
      logic we;
      int n;
      ea = s1 + imm;
      we = op == OP_SB || op == OP_SW;
      be = (op == OP_LB || op == OP_SB) ? 4'b0001 << ea[1:0] : 4'hF;
      wd = op == OP_SB ? {24'h0, s2[7:0]} * 32'h01010101 : s2;
      b8 = 8'(rdata >> (8 * ea[1:0]));
      res = op == OP_LB ? {{24{b8[7]}}, b8} : rdata;
      step();
      chk("fu_ready2_idle", io.fu_ready[2], 1);
      l_v = 1; l_op = op; l_s1 = s1; l_s2 = s2; l_imm = imm; l_d = d; l_r = r;
      step();
      l_v = 0;
      if (!(op >= OP_LB && op <= OP_SW)) return;
      n = 0;
      while (!io.mem_req_valid && n < 8) begin step(); n++; end
      chk("req_latency", n, 0);
      for (int i = 0; i <= rd_dly; i++) begin
         chk("req_valid", io.mem_req_valid, 1);
         chk("req_we", io.mem_req_we, we);
         chk("req_addr", io.mem_req_addr, ea);
         chk("req_be", io.mem_req_be, be);
         if (we) chk("req_wdata", io.mem_req_wdata, wd);
         chk("fu_ready2_req", io.fu_ready[2], 0);
         m_rdy = i == rd_dly;
         m_rv = i < rd_dly ? 1'($urandom) : 1'b0;
         m_rd = $urandom;
         if (we && i == rd_dly) sq.push_back('{cyc + 1, r});
         step();
      end
      m_rdy = 0; m_rv = 0;
      if (we) begin
         chk("fu_ready2_after_store", io.fu_ready[2], 1);
         return;
      end
      for (int i = 0; i < rs_dly; i++) begin
         chk("fu_ready2_wait", io.fu_ready[2], 0);
         step();
      end
      chk("fu_ready2_wait", io.fu_ready[2], 0);
      m_rv = 1; m_rd = rdata;
      qa[2].push_back('{cyc + 1, d, r, res});
      step();
      m_rv = 0;
      chk("fu_ready2_done", io.fu_ready[2], 0);
      step();
      chk("fu_ready2_back", io.fu_ready[2], 1);
   endtask
   // model of the wakeup set: broadcasts land the following cycle, alloc clears win
   always @(posedge clk or posedge rst)
      if (rst) rdy <= '1;
      else rdy <= ((rdy | setm_q) & ~(al_v ? 64'd1 << al_p : 64'd0)) | 64'd1;
   always @(negedge clk) begin
      logic [63:0] sm, cm;
      exp_t e;
      st_t s;
      sm = '0;
      if (rst) setm_q = '0;
      else begin
         for (int k = 0; k < 3; k++)
            if (qa[k].size() != 0 && qa[k][0].due == cyc) begin
               e = qa[k].pop_front();
               chk($sformatf("bcast%0d_valid", k), io.bcast_valid[k], 1);
               chk($sformatf("bcast%0d_preg", k), io.bcast_preg[k], e.preg);
               chk($sformatf("bcast%0d_rob", k), io.bcast_rob[k], e.rob);
               chk($sformatf("bcast%0d_data", k), io.bcast_data[k], e.data);
               sm[e.preg] = 1'b1;
            end else chk($sformatf("bcast%0d_idle", k), io.bcast_valid[k], 0);
         if (sq.size() != 0 && sq[0].due == cyc) begin
            s = sq.pop_front();
            chk("store_done_valid", io.store_done_valid, 1);
            chk("store_done_rob", io.store_done_rob, s.rob);
         end else chk("store_done_idle", io.store_done_valid, 0);
         cm = al_v ? 64'd1 << al_p : 64'd0;
`ifdef WAKEUP_BYPASS_EN
         chk("preg_ready", io.preg_ready, rdy | (sm & ~cm));
`else
         chk("preg_ready", io.preg_ready, rdy);
`endif
         setm_q = sm;
      end
   end
   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      a_v = '0; a_op = '0; a_s1 = '0; a_s2 = '0; a_imm = '0; a_d = '0; a_r = '0;
      l_v = 0; l_op = 0; l_s1 = 0; l_s2 = 0; l_imm = 0; l_d = 0; l_r = 0;
      al_v = 0; al_p = 0; m_rdy = 0; m_rv = 0; m_rd = 0;
      repeat (2) step();
      chk("rst_bcast_valid", io.bcast_valid, 0);
      chk("rst_bcast_data", io.bcast_data[0] | io.bcast_data[1] | io.bcast_data[2], 0);
      chk("rst_store_done", {io.store_done_valid, io.store_done_rob}, 0);
      chk("rst_mem_req", {io.mem_req_valid, io.mem_req_we, io.mem_req_be, io.mem_req_addr}, 0);
      chk("rst_fu_ready", io.fu_ready, 3'b111);
      chk("rst_preg_ready", io.preg_ready, '1);
      rst = 0;
      step(); al_v = 1; al_p = 12;
      step(); al_p = 13;
      step(); al_p = 14;
      step(); al_v = 0;
      alu(0, OP_ADDI, 32'd5, 32'd0, 32'hFFFFFFF9, 6'd12, 6'd1, 1);
      alu(1, OP_SRAI, 32'h80000010, 32'd0, 32'd4, 6'd13, 6'd2, 1);
      step();
      alu(0, OP_ADD, 0, 0, 0, 0, 0, 0);
      alu(1, OP_LUI, 32'd0, 32'd0, 32'h12345000, 6'd14, 6'd3, 1);
      step();
      alu(0, OP_ADDI, 32'd1, 32'd0, 32'd1, 6'd9, 6'd4, 1);
      alu(1, OP_ADD, 0, 0, 0, 0, 0, 0);
      step();
      alu(0, OP_ADD, 0, 0, 0, 0, 0, 0);
      al_v = 1; al_p = 9;
      step(); al_p = 0;
      step(); al_v = 0;
      step();
      chk("preg9_alloc_wins", io.preg_ready[9], 0);
      chk("preg0_pinned", io.preg_ready[0], 1);
      mem_op(OP_LB, 32'h100, 32'h0, 32'h3, 6'd22, 6'd23, 0, 0, 32'h80FFFFFF);
      mem_op(OP_SB, 32'h200, 32'hAB, 32'h1, 6'd24, 6'd25, 3, 0, 32'h0);
      mem_op(OP_LW, 32'h400, 32'h0, 32'h8, 6'd26, 6'd27, 0, 0, 32'hCAFEF00D);
      mem_op(OP_SW, 32'h500, 32'h11223344, 32'h4, 6'd28, 6'd29, 1, 0, 32'h0);
      fork
         begin
            repeat (300) begin
               step();
               for (int k = 0; k < 2; k++)
                  alu(k, 4'($urandom_range(0, 11)), $urandom, $urandom,
                      $urandom_range(0, 1) ? $urandom : $urandom_range(0, 31),
                      6'($urandom), 6'($urandom), $urandom_range(0, 3) != 0);
               al_v = $urandom_range(0, 3) == 0;
               al_p = 6'($urandom);
            end
            step();
            a_v = '0; al_v = 0;
         end
         begin
            repeat (30) begin
               logic [3:0] op;
               case ($urandom_range(0, 4))
                  0: op = OP_LB;
                  1: op = OP_LW;
                  2: op = OP_SB;
                  3: op = OP_SW;
                  default: op = 4'($urandom_range(0, 6));
               endcase
               mem_op(op, $urandom, $urandom, $urandom_range(0, 15), 6'($urandom), 6'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            end
         end
      join
      repeat (3) step();
      l_v = 1; l_op = OP_LW; l_s1 = 32'h40; l_imm = 0; l_d = 6'd7; l_r = 6'd5;
      step();
      l_v = 0; m_rdy = 1;
      step();
      m_rdy = 0;
      chk("abort_in_wait", {io.mem_req_valid, io.fu_ready[2]}, 2'b00);
      #2 rst = 1;
      #1;
      chk("abort_bcast", io.bcast_valid, 0);
      chk("abort_fu_ready", io.fu_ready, 3'b111);
      chk("abort_preg_ready", io.preg_ready, '1);
      chk("abort_store_mem", {io.store_done_valid, io.mem_req_valid}, 0);
      step();
      rst = 0; m_rv = 1; m_rd = 32'h12345678;
      step();
      m_rv = 0;
      repeat (3) step();
      chk("abort_idle", io.fu_ready, 3'b111);
      chk("queues_drained", qa[0].size() + qa[1].size() + qa[2].size() + sq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
